// File: rtl/reg_file_mp.sv
`default_nettype none
// ============================================================================
//  Module      : reg_file_mp
//  Description : Multi-port register file. Two combinational read ports,
//                two write ports (port B wins on an address collision), an
//                optional hardwired-zero register 0, and a sequential clear
//                engine that sweeps every register to zero, one per cycle.
//  Macro       : REGFILE_BYPASS_EN - when defined, a read that matches an
//                accepted same-cycle write returns the write data.
//  Ports       : clk      - clock, all state updates on the rising edge
//                reset    - synchronous, active-low reset
//                ra_addr  / ra_data - read port A address / data
//                rb_addr  / rb_data - read port B address / data
//                wa_en, wa_addr, wa_data - write port A
//                wb_en, wb_addr, wb_data - write port B
//                clr_req  - request a sequential clear of all registers
//                clr_busy - clear sweep in progress, writes are blocked
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_file_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] ra_addr,
  output logic [DATA_W-1:0] ra_data,
  input  logic [ADDR_W-1:0] rb_addr,
  output logic [DATA_W-1:0] rb_data,
  input  logic              wa_en,
  input  logic [ADDR_W-1:0] wa_addr,
  input  logic [DATA_W-1:0] wa_data,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              clr_req,
  output logic              clr_busy
);

  localparam int                DEPTH      = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] c_last_idx = {ADDR_W{1'b1}};
  localparam logic              c_zero_en  = (ZERO_REG != 0);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_cnt;
  logic [DATA_W-1:0] r_regs [DEPTH];

  logic w_busy;
  logic w_wa_acc;
  logic w_wb_acc;

  assign w_busy   = (r_state == ST_CLEAR);
  assign clr_busy = w_busy;

  // A write is accepted only outside the sweep, and never to a hardwired r0.
  assign w_wa_acc = wa_en & ~w_busy & ~(c_zero_en & (wa_addr == '0));
  assign w_wb_acc = wb_en & ~w_busy & ~(c_zero_en & (wb_addr == '0));

  // ---------------- clear engine ----------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (clr_req) w_state_nxt = ST_CLEAR;
      // clr_req is not looked at here, so a request mid-sweep neither
      // restarts nor extends it.
      ST_CLEAR: if (r_cnt == c_last_idx) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Counter is held at zero while idle, so each sweep starts at register 0.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (r_state == ST_IDLE) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + ADDR_W'(1);
    end
  end

  // ---------------- storage ----------------
  // Port B is assigned last so it overrides port A on the same address.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_busy) begin
      r_regs[r_cnt] <= '0;
    end else begin
      if (w_wa_acc) r_regs[wa_addr] <= wa_data;
      if (w_wb_acc) r_regs[wb_addr] <= wb_data;
    end
  end

  // ---------------- read ports ----------------
  // Busy and hardwired-zero override everything, including forwarding.
  function automatic logic [DATA_W-1:0] f_read(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] v;
    v = r_regs[a];
`ifdef REGFILE_BYPASS_EN
    if (w_wa_acc && (wa_addr == a)) v = wa_data;
    if (w_wb_acc && (wb_addr == a)) v = wb_data;
`endif
    if (w_busy || (c_zero_en && (a == '0))) v = '0;
    return v;
  endfunction

  always_comb begin
    ra_data = f_read(ra_addr);
    rb_data = f_read(rb_addr);
  end

endmodule
`default_nettype wire

// File: tb/tb_reg_file_mp.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reg_file_mp
//  Description : Self-checking bench for reg_file_mp. Drives two instances
//                (ZERO_REG=1 and ZERO_REG=0) with the same directed vectors,
//                checks both against an array-based model every cycle, and
//                pins the model with hand-computed literal expectations.
//  Macro       : REGFILE_BYPASS_EN - same meaning as in the design.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_file_mp;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  ra_addr, rb_addr, wa_addr, wb_addr;
  logic [31:0] wa_data, wb_data;
  logic        wa_en, wb_en, clr_req;
  logic [31:0] ra_z, rb_z, ra_n, rb_n;
  logic        busy_z, busy_n;

  int n_tests = 0;
  int n_fail  = 0;
  bit check_en = 1'b0;

  always #5 clk = ~clk;

  reg_file_mp #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1)) u_dut_z (
    .clk(clk), .reset(reset),
    .ra_addr(ra_addr), .ra_data(ra_z), .rb_addr(rb_addr), .rb_data(rb_z),
    .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .clr_req(clr_req), .clr_busy(busy_z)
  );

  reg_file_mp #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(0)) u_dut_n (
    .clk(clk), .reset(reset),
    .ra_addr(ra_addr), .ra_data(ra_n), .rb_addr(rb_addr), .rb_data(rb_n),
    .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .clr_req(clr_req), .clr_busy(busy_n)
  );

  // ---------------- model ----------------
  // The sweep is modelled as "everything zero at once, then busy for 32
  // cycles": reads return 0 and writes are dropped while busy, so the
  // visible behaviour is identical to a one-register-per-cycle sweep.
  logic [31:0] mem_z [32];
  logic [31:0] mem_n [32];
  int          busy_left = 0;

  task automatic model_zero_all();
    for (int i = 0; i < 32; i++) begin
      mem_z[i] = '0;
      mem_n[i] = '0;
    end
  endtask

  always @(posedge clk) begin
    if (!reset) begin
      model_zero_all();
      busy_left = 0;
    end else if (busy_left > 0) begin
      busy_left = busy_left - 1;
    end else begin
      if (wa_en) begin
        if (wa_addr != 0) mem_z[wa_addr] = wa_data;
        mem_n[wa_addr] = wa_data;
      end
      if (wb_en) begin
        if (wb_addr != 0) mem_z[wb_addr] = wb_data;
        mem_n[wb_addr] = wb_data;
      end
      if (clr_req) begin
        model_zero_all();
        busy_left = 32;
      end
    end
  end

  function automatic logic [31:0] exp_rd(input bit z, input logic [4:0] a);
    logic [31:0] v;
    if (busy_left > 0) return 32'h0;
    if (z && (a == 0)) return 32'h0;
    v = z ? mem_z[a] : mem_n[a];
`ifdef REGFILE_BYPASS_EN
    if (wa_en && (!z || wa_addr != 0) && wa_addr == a) v = wa_data;
    if (wb_en && (!z || wb_addr != 0) && wb_addr == a) v = wb_data;
`endif
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Every-cycle comparison on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (check_en) begin
      chk("cyc_ra_z",   ra_z,          exp_rd(1'b1, ra_addr));
      chk("cyc_rb_z",   rb_z,          exp_rd(1'b1, rb_addr));
      chk("cyc_busy_z", {31'b0, busy_z}, {31'b0, busy_left > 0});
      chk("cyc_ra_n",   ra_n,          exp_rd(1'b0, ra_addr));
      chk("cyc_rb_n",   rb_n,          exp_rd(1'b0, rb_addr));
      chk("cyc_busy_n", {31'b0, busy_n}, {31'b0, busy_left > 0});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int n;
    reset = 1'b0; clr_req = 1'b0;
    wa_en = 1'b0; wb_en = 1'b0;
    wa_addr = '0; wb_addr = '0; wa_data = '0; wb_data = '0;
    ra_addr = '0; rb_addr = '0;
    tick(); tick();
    check_en = 1'b1;
    reset = 1'b1;
    #1;
    chk("rst_busy", {31'b0, busy_z}, 32'h0);

    // Write r5, then reset: contents must vanish.
    wa_en = 1'b1; wa_addr = 5'd5; wa_data = 32'hDEADBEEF;
    tick();
    wa_en = 1'b0; ra_addr = 5'd5; #1;
    chk("r5_written", ra_z, 32'hDEADBEEF);
    reset = 1'b0;
    tick();
    reset = 1'b1; #1;
    chk("r5_after_reset", ra_z, 32'h0);
    chk("busy_after_reset", {31'b0, busy_z}, 32'h0);

    // Same-address collision: port B wins.
    wa_en = 1'b1; wa_addr = 5'd7; wa_data = 32'h11;
    wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'h22;
    tick();
    wa_en = 1'b0; wb_en = 1'b0; ra_addr = 5'd7; #1;
    chk("collide_r7", ra_z, 32'h22);

    // Different addresses: both stored.
    wa_en = 1'b1; wa_addr = 5'd4; wa_data = 32'h44;
    wb_en = 1'b1; wb_addr = 5'd6; wb_data = 32'h66;
    tick();
    wa_en = 1'b0; wb_en = 1'b0; ra_addr = 5'd4; rb_addr = 5'd6; #1;
    chk("dual_r4", ra_z, 32'h44);
    chk("dual_r6", rb_z, 32'h66);

    // Same-cycle read of a write target.
    wa_en = 1'b1; wa_addr = 5'd3; wa_data = 32'hA5A5A5A5; ra_addr = 5'd3; #1;
`ifdef REGFILE_BYPASS_EN
    chk("bypass_r3", ra_z, 32'hA5A5A5A5);
`else
    chk("nobypass_r3", ra_z, 32'h0);
`endif
    tick();
    wa_en = 1'b0; #1;
    chk("r3_next", ra_z, 32'hA5A5A5A5);

    // Register 0 behaviour on both variants.
    wa_en = 1'b1; wa_addr = 5'd0; wa_data = 32'hFFFFFFFF;
    tick();
    wa_en = 1'b0; ra_addr = 5'd0; #1;
    chk("r0_zero_reg", ra_z, 32'h0);
    chk("r0_plain_reg", ra_n, 32'hFFFFFFFF);

    // Fill r1..r31 with their index, then sweep.
    for (int i = 1; i < 32; i++) begin
      wa_en = 1'b1; wa_addr = 5'(i); wa_data = 32'(i);
      tick();
    end
    wa_en = 1'b0; ra_addr = 5'd17; #1;
    chk("fill_r17", ra_z, 32'd17);
    wa_en = 1'b1; wa_addr = 5'd12; wa_data = 32'hCC;   // stored, then swept
    clr_req = 1'b1;
    tick();
    wa_en = 1'b0; clr_req = 1'b0;
    n = 0;
    while (busy_z && n < 40) begin
      n++;
      wa_en   = (n == 5);
      wa_addr = 5'd9; wa_data = 32'h99;
      clr_req = (n == 8);
      tick();
    end
    wa_en = 1'b0; clr_req = 1'b0;
    chk("busy_cycles", 32'(n), 32'd32);
    ra_addr = 5'd9; rb_addr = 5'd12; #1;
    chk("r9_after_sweep", ra_z, 32'h0);
    chk("r12_after_sweep", rb_z, 32'h0);
    ra_addr = 5'd31; rb_addr = 5'd1; #1;
    chk("r31_after_sweep", ra_z, 32'h0);
    chk("r1_after_sweep", rb_z, 32'h0);

    // Reset in the middle of a sweep.
    wa_en = 1'b1; wa_addr = 5'd2;  wa_data = 32'h2222;
    wb_en = 1'b1; wb_addr = 5'd20; wb_data = 32'h2020;
    tick();
    wa_en = 1'b0; wb_en = 1'b0;
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    for (int k = 1; k < 10; k++) tick();
    chk("busy_mid_sweep", {31'b0, busy_z}, 32'h1);
    reset = 1'b0;
    tick();
    reset = 1'b1; ra_addr = 5'd2; rb_addr = 5'd20; #1;
    chk("busy_after_mid_reset", {31'b0, busy_z}, 32'h0);
    chk("r2_after_mid_reset", ra_z, 32'h0);
    chk("r20_after_mid_reset", rb_z, 32'h0);
    wa_en = 1'b1; wa_addr = 5'd2; wa_data = 32'h1234;
    tick();
    wa_en = 1'b0; #1;
    chk("write_after_mid_reset", ra_z, 32'h1234);
    tick(); tick();

    check_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
